// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, the registered
// instruction presented to decode, and the branch/jump resolution returned
// by execute. master = fetch stage, slave = memory/decode/execute side.
//
// Ports:
//   imem_req/imem_addr        read request and word address (fetch -> imem)
//   imem_rdata/imem_valid     instruction word and its valid (imem -> fetch)
//   instr/instr_valid/instr_pc/link_addr   held instruction for decode/execute
//   exec_done/branch/branch_cond/jump/jump_use_reg/reg_target   retirement + resolution
//   fetch_err                 misaligned-target trap flag
interface instruction_fetch_if;
   logic          imem_req;
   logic [31:0]   imem_addr;
   logic [0:31]   imem_rdata;
   logic          imem_valid;
   logic [0:31]   instr;
   logic          instr_valid;
   logic [31:0]   instr_pc;
   logic [31:0]   link_addr;
   logic          exec_done;
   logic          branch;
   logic          branch_cond;
   logic          jump;
   logic          jump_use_reg;
   logic [31:0]   reg_target;
   logic          fetch_err;

   modport master (
      output imem_req, imem_addr,
      input  imem_rdata, imem_valid,
      output instr, instr_valid, instr_pc, link_addr,
      input  exec_done, branch, branch_cond, jump, jump_use_reg, reg_target,
      output fetch_err
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_rdata, imem_valid,
      input  instr, instr_valid, instr_pc, link_addr,
      output exec_done, branch, branch_cond, jump, jump_use_reg, reg_target,
      input  fetch_err
   );
endinterface

// File: rtl/instruction_fetch.sv
// Purpose: DLX fetch stage; owns the PC, fetches one word at a time, holds it until retired.
// Latency: response -> instr_valid next cycle; exec_done -> new imem_addr next cycle (2-cycle min per instr).
// Backpressure: waits in REQ for imem_valid, waits in HOLD for exec_done; never issues a second request.
//
// Ports: clk, reset (synchronous, active-high); bus = instruction_fetch_if.master
// (memory request/response, held instruction, execute resolution, fetch_err).
// Parameter RESET_PC: PC loaded on reset.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: a misaligned next PC traps into
// ERR (fetch_err=1, fetch stops until reset). Without it the low two PC bits
// are cleared and fetch carries on; fetch_err is tied low.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   instruction_fetch_if.master bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
   localparam logic [1:0] ERR  = 2'd3;
`endif

   logic [1:0]  state;
   logic [31:0] pc;
   logic [0:31] instr_q;
   logic [31:0] instr_pc_q;

   logic [31:0] seq_pc;
   logic [31:0] jump_tgt;
   logic [31:0] branch_tgt;
   logic [31:0] next_pc;
   logic [31:0] pc_load;

   // instr uses MSB-first numbering: instr[6:31] is the 26-bit jump offset,
   // instr[16:31] the 16-bit branch offset; both are byte offsets, unshifted.
   assign seq_pc     = instr_pc_q + 32'd4;
   assign jump_tgt   = seq_pc + {{6{instr_q[6]}}, instr_q[6:31]};
   assign branch_tgt = seq_pc + {{16{instr_q[16]}}, instr_q[16:31]};

   // Register jumps beat PC-relative jumps, which beat taken branches.
   always_comb begin
      next_pc = seq_pc;
      if (bus.jump && bus.jump_use_reg)
         next_pc = bus.reg_target;
      else if (bus.jump)
         next_pc = jump_tgt;
      else if (bus.branch && bus.branch_cond)
         next_pc = branch_tgt;
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   // Keep the offending target visible on imem_addr while trapped.
   assign pc_load = next_pc;
`else
   assign pc_load = next_pc & 32'hFFFF_FFFC;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (bus.imem_valid) begin
                  instr_q    <= bus.imem_rdata;
                  instr_pc_q <= pc;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               if (bus.exec_done) begin
                  pc <= pc_load;
`ifdef FETCH_MISALIGN_TRAP_EN
                  state <= (next_pc[1:0] != 2'b00) ? ERR : REQ;
`else
                  state <= REQ;
`endif
               end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ERR: state <= ERR;
`endif
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.imem_req    = (state == REQ);
   assign bus.imem_addr   = pc;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = (state == HOLD);
   assign bus.instr_pc    = instr_pc_q;
   assign bus.link_addr   = instr_pc_q + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign bus.fetch_err   = (state == ERR);
`else
   assign bus.fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: the driver acts as instruction
// memory and execute stage, pushing expected fetch addresses and expected
// held instructions; an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_instruction_fetch;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic clk = 1'b0;
   logic reset;
   instruction_fetch_if bus ();

   instruction_fetch #(.RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc;
   } iexp_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_addr [$];
   iexp_t       exp_instr [$];
   logic [31:0] mem_ovr [logic [31:0]];
   logic [31:0] m_pc;
   bit          trap_expected = 1'b0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: DUT did not respond within the cycle budget (t=%0t)", name, $time);
   endtask

   // Instruction memory contents: a few fixed words, otherwise a hash of the address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      logic [31:0] h;
      if (mem_ovr.exists(a)) return mem_ovr[a];
      h = a * 32'h9E37_79B1;
      h = h ^ (h >> 15) ^ 32'h5BD1_E995;
      h = h * 32'h85EB_CA6B;
`ifdef FETCH_MISALIGN_TRAP_EN
      h = h & 32'hFFFF_FFFC;
`endif
      return h;
   endfunction

   // Reference next-PC from the resolution rules, with signed offsets.
   function automatic logic [31:0] model_next(input logic [31:0] ipc, input logic [31:0] iw,
                                              input bit j, input bit jr, input bit br,
                                              input bit bc, input logic [31:0] rt);
      logic [31:0] t;
      if (j && jr)      t = rt;
      else if (j)       t = ipc + 32'd4 + 32'($signed(iw[25:0]));
      else if (br && bc) t = ipc + 32'd4 + 32'($signed(iw[15:0]));
      else              t = ipc + 32'd4;
`ifndef FETCH_MISALIGN_TRAP_EN
      t = t & 32'hFFFF_FFFC;
`endif
      return t;
   endfunction

   task automatic idle_inputs();
      bus.imem_valid   = 1'b0;
      bus.imem_rdata   = '0;
      bus.exec_done    = 1'b0;
      bus.branch       = 1'b0;
      bus.branch_cond  = 1'b0;
      bus.jump         = 1'b0;
      bus.jump_use_reg = 1'b0;
      bus.reg_target   = '0;
   endtask

   // Junk on inputs that must be ignored in the current state.
   task automatic noise(input bit allow_valid, input bit allow_done);
      bus.imem_valid   = allow_valid ? 1'($urandom % 2) : 1'b0;
      bus.imem_rdata   = $urandom;
      bus.exec_done    = allow_done ? 1'($urandom % 2) : 1'b0;
      bus.branch       = 1'($urandom % 2);
      bus.branch_cond  = 1'($urandom % 2);
      bus.jump         = 1'($urandom % 2);
      bus.jump_use_reg = 1'($urandom % 2);
      bus.reg_target   = $urandom;
   endtask

   // Called at a negedge; returns at the negedge after the response edge.
   task automatic fetch(input int wc);
      int budget;
      budget = 0;
      while (bus.imem_req !== 1'b1) begin
         if (budget == 20) begin timeout("req_wait"); return; end
         noise(1'b1, 1'b1);
         @(negedge clk);
         budget++;
      end
      for (int i = 0; i < wc; i++) begin
         noise(1'b0, 1'b1);
         @(negedge clk);
      end
      exp_instr.push_back('{mem(m_pc), m_pc});
      idle_inputs();
      bus.imem_valid = 1'b1;
      bus.imem_rdata = mem(bus.imem_addr);
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic retire(input int hc, input bit j, input bit jr, input bit br,
                         input bit bc, input logic [31:0] rt);
      int budget;
      logic [31:0] nxt;
      budget = 0;
      while (bus.instr_valid !== 1'b1) begin
         if (budget == 20) begin timeout("hold_wait"); return; end
         @(negedge clk);
         budget++;
      end
      for (int i = 0; i < hc; i++) begin
         noise(1'b1, 1'b0);
         @(negedge clk);
      end
      nxt = model_next(m_pc, mem(m_pc), j, jr, br, bc, rt);
`ifdef FETCH_MISALIGN_TRAP_EN
      if (nxt[1:0] != 2'b00) trap_expected = 1'b1;
      else exp_addr.push_back(nxt);
`else
      exp_addr.push_back(nxt);
`endif
      idle_inputs();
      bus.exec_done    = 1'b1;
      bus.jump         = j;
      bus.jump_use_reg = jr;
      bus.branch       = br;
      bus.branch_cond  = bc;
      bus.reg_target   = rt;
      @(negedge clk);
      idle_inputs();
      m_pc = nxt;
   endtask

   task automatic run_instr(input int wc, input int hc, input bit j, input bit jr,
                            input bit br, input bit bc, input logic [31:0] rt);
      fetch(wc);
      retire(hc, j, jr, br, bc, rt);
   endtask

   // ---------------- monitor ----------------
   bit          prev_req = 1'b0;
   bit          prev_iv  = 1'b0;
   logic [31:0] held_addr;
   iexp_t       held_instr;
   bit          s_acc, s_ret, s_rst;

   always begin
      @(posedge clk);
      s_acc = (bus.imem_req === 1'b1) && (bus.imem_valid === 1'b1);
      s_ret = (bus.instr_valid === 1'b1) && (bus.exec_done === 1'b1);
      s_rst = (reset === 1'b1);
      #1;
      if (!s_rst && s_acc) chk1("resp_to_instr_valid", bus.instr_valid, 1'b1);
      if (!s_rst && s_ret && !trap_expected) chk1("retire_to_req", bus.imem_req, 1'b1);
      if (bus.imem_req === 1'b1 && bus.instr_valid === 1'b1)
         chk1("req_hold_exclusive", 1'b1, 1'b0);

      if (bus.imem_req === 1'b1 && !prev_req) begin
         if (exp_addr.size() == 0) begin
            chk32("spurious_req_addr", bus.imem_addr, 32'hxxxx_xxxx);
         end else begin
            held_addr = exp_addr.pop_front();
            chk32("req_addr", bus.imem_addr, held_addr);
         end
      end else if (bus.imem_req === 1'b1) begin
         chk32("req_addr_stable", bus.imem_addr, held_addr);
      end

      if (bus.instr_valid === 1'b1 && !prev_iv) begin
         if (exp_instr.size() == 0) begin
            chk32("spurious_instr", bus.instr, 32'hxxxx_xxxx);
         end else begin
            held_instr = exp_instr.pop_front();
            chk32("instr", bus.instr, held_instr.word);
            chk32("instr_pc", bus.instr_pc, held_instr.pc);
            chk32("link_addr", bus.link_addr, held_instr.pc + 32'd4);
         end
      end else if (bus.instr_valid === 1'b1) begin
         chk32("instr_stable", bus.instr, held_instr.word);
         chk32("instr_pc_stable", bus.instr_pc, held_instr.pc);
      end

      prev_req = (bus.imem_req === 1'b1);
      prev_iv  = (bus.instr_valid === 1'b1);
   end

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      reset = 1'b1;
      mem_ovr[32'h0000_0100] = 32'h2000_0000;
      mem_ovr[32'h0000_0200] = 32'h1000_FFF8;   // branch offset -8
      mem_ovr[32'h0000_0010] = 32'h0BFF_FFF0;   // jump offset 26'h3FFFFF0 = -16
      noise(1'b1, 1'b1);
      repeat (3) @(negedge clk);

      chk1 ("rst_imem_req", bus.imem_req, 1'b0);
      chk1 ("rst_instr_valid", bus.instr_valid, 1'b0);
      chk1 ("rst_fetch_err", bus.fetch_err, 1'b0);
      chk32("rst_instr", bus.instr, 32'h0);
      chk32("rst_instr_pc", bus.instr_pc, 32'h0);
      chk32("rst_imem_addr", bus.imem_addr, RST_PC);

      // Release: cycle 0 is IDLE, cycle 1 requests RESET_PC.
      idle_inputs();
      m_pc = RST_PC;
      exp_addr.push_back(RST_PC);
      reset = 1'b0;
      chk1("cycle0_no_req", bus.imem_req, 1'b0);
      @(negedge clk);
      chk1 ("cycle1_req", bus.imem_req, 1'b1);
      chk32("cycle1_addr", bus.imem_addr, 32'h0000_0100);

      // Zero-wait memory: instruction held in cycle 2.
      fetch(0);
      chk1 ("cycle2_instr_valid", bus.instr_valid, 1'b1);
      chk32("cycle2_instr", bus.instr, 32'h2000_0000);
      chk32("cycle2_instr_pc", bus.instr_pc, 32'h0000_0100);
      chk32("cycle2_link", bus.link_addr, 32'h0000_0104);
      retire(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200);
      chk32("jr_to_200", bus.imem_addr, 32'h0000_0200);

      run_instr(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      chk32("branch_taken", bus.imem_addr, 32'h0000_01FC);
      run_instr(0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200);
      run_instr(1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk32("branch_not_taken", bus.imem_addr, 32'h0000_0204);
      run_instr(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400);
      chk32("jr_beats_branch", bus.imem_addr, 32'h0000_0400);
      run_instr(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010);
      run_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk32("j_negative", bus.imem_addr, 32'h0000_0004);
      run_instr(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
      run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk32("pc_wrap", bus.imem_addr, 32'h0000_0000);
      run_instr(3, 4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk32("slow_mem_exec", bus.imem_addr, 32'h0000_0004);

      // Reset during REQ with a response arriving in the reset and IDLE cycles.
      reset = 1'b1;
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk1 ("midreq_rst_req", bus.imem_req, 1'b0);
      chk1 ("midreq_rst_iv", bus.instr_valid, 1'b0);
      chk32("midreq_rst_addr", bus.imem_addr, RST_PC);
      m_pc = RST_PC;
      exp_addr.push_back(RST_PC);
      reset = 1'b0;
      bus.imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      idle_inputs();
      chk1 ("late_resp_ignored", bus.instr_valid, 1'b0);
      chk1 ("restart_req", bus.imem_req, 1'b1);
      chk32("restart_addr", bus.imem_addr, RST_PC);

      // Randomized traffic.
      for (int k = 0; k < 250; k++) begin
         bit          rj, rjr, rbr, rbc;
         logic [31:0] rt;
         rj  = (($urandom % 4) == 0);
         rjr = 1'($urandom % 2);
         rbr = 1'($urandom % 2);
         rbc = 1'($urandom % 2);
         rt  = (($urandom % 4) == 0) ? 32'hFFFF_FFFC : 32'($urandom);
`ifdef FETCH_MISALIGN_TRAP_EN
         rt[1:0] = 2'b00;
`endif
         run_instr(int'($urandom % 4), int'($urandom % 4), rj, rjr, rbr, rbc, rt);
      end

      // Misaligned register jump.
      run_instr(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0402);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk1 ("trap_fetch_err", bus.fetch_err, 1'b1);
      chk1 ("trap_no_req", bus.imem_req, 1'b0);
      chk1 ("trap_no_iv", bus.instr_valid, 1'b0);
      chk32("trap_pc_unmasked", bus.imem_addr, 32'h0000_0402);
      for (int i = 0; i < 3; i++) begin
         noise(1'b1, 1'b1);
         @(negedge clk);
         chk1("trap_sticky_err", bus.fetch_err, 1'b1);
         chk1("trap_sticky_no_req", bus.imem_req, 1'b0);
      end
      idle_inputs();
`else
      chk32("misalign_masked", bus.imem_addr, 32'h0000_0400);
      chk1 ("no_fetch_err", bus.fetch_err, 1'b0);
`endif

      @(negedge clk);
      chk32("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
      chk32("instr_queue_drained", 32'(exp_instr.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage for the DLX single-cycle core. It sits directly upstream of the instruction decoder. It owns the program counter and requests instruction words from instruction memory over a valid handshake. It holds each fetched word stable for decode/execute until retirement, then computes the next PC from the branch/jump resolution returned by execute.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  32  word address being fetched. Equals pc. Stable while imem_req=1.
- imem_rdata  input  [0:31]  instruction word. Valid when imem_valid=1.
- imem_valid  input  1  read data valid. Ignored unless state is REQ.
- instr  output  [0:31]  registered instruction presented to decode.
- instr_valid  output  1  instr is valid and awaiting retirement.
- instr_pc  output  32  address of instr.
- link_addr  output  32  instr_pc+4, used as the JAL/JALR write-back value.
- exec_done  input  1  execute retires instr this cycle; resolution inputs are valid.
- branch  input  1  decoded BRANCH for instr.
- branch_cond  input  1  ALU result bit 31 (1 = condition true).
- jump  input  1  decoded JUMP.
- jump_use_reg  input  1  decoded JUMP_USE_REG (JR/JALR).
- reg_target  input  32  rs1 value for register jumps.
- fetch_err  output  1  misaligned-target trap flag (see Configuration).

## Operation
- States: IDLE, REQ, HOLD, ERR. ERR is reachable only with the macro defined.
- IDLE: entered on reset for exactly one cycle, then → REQ.
- REQ: imem_req=1, imem_addr=pc. When imem_valid=1:
  - instr ← imem_rdata
  - instr_pc ← pc
  - → HOLD
- HOLD: instr_valid=1.
  - When exec_done=1: pc ← next_pc, → REQ.
  - When exec_done=0: remain in HOLD, and instr, instr_pc and link_addr hold their values.
- next_pc selection, evaluated in priority order:
  - jump & jump_use_reg → reg_target
  - jump → instr_pc+4+sext(instr[6:31])
  - branch & branch_cond → instr_pc+4+sext(instr[16:31])
  - otherwise → instr_pc+4
- Arithmetic rules:
  - All sums are 32-bit, modulo 2^32. Wrap from 32'hFFFF_FFFC+4 gives 32'h0000_0000.
  - Offsets are byte offsets and are not shifted.
- Combinations on exec_done:
  - jump and branch both high: jump wins.
  - branch high with branch_cond=0: fall through to instr_pc+4.
- exec_done outside HOLD is ignored.
- imem_valid outside REQ is ignored. This includes a late response that arrives after reset.
- Reset (any state, including mid-request):
  - pc ← RESET_PC, state ← IDLE, instr ← 0, instr_pc ← 0.
  - instr_valid=0, imem_req=0, fetch_err=0.
  - Any in-flight memory response is dropped.

## Timing
- Outputs are registered or decoded from state.
  - imem_addr and link_addr follow pc and instr_pc respectively.
- Reset sequence:
  - Reset deasserts at cycle 0; IDLE during cycle 0.
  - imem_req=1 with imem_addr=RESET_PC in cycle 1.
- Zero-wait memory:
  - imem_valid in the same cycle as imem_req gives instr_valid=1 the next cycle.
  - Minimum throughput with exec_done in the first HOLD cycle: one instruction per 2 cycles (REQ, HOLD).
- Each imem wait cycle adds one REQ cycle.
- The new pc is visible on imem_addr in the cycle after exec_done.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - If next_pc[1:0]≠0 at exec_done, pc ← next_pc unmasked and state → ERR.
  - ERR: fetch_err=1, imem_req=0, instr_valid=0. ERR is left only by reset.
- FETCH_MISALIGN_TRAP_EN undefined:
  - next_pc[1:0] is forced to 2'b00 and fetch continues.
  - fetch_err is tied to 0.
  - ERR does not exist.

## Test plan
- Reset release, RESET_PC=32'h100, zero-wait memory returning 32'h2000_0000 → imem_req in cycle 1 at 32'h100; instr_valid in cycle 2 with instr_pc=32'h100 and link_addr=32'h104.
- Taken branch at 32'h200, instr[16:31]=16'hFFF8, branch=1, branch_cond=1 → next imem_addr=32'h1FC. Same stimulus with branch_cond=0 → next imem_addr=32'h204.
- JR with reg_target=32'h400 and branch=1 simultaneously → next imem_addr=32'h400. J at 32'h10 with offset 26'h3FFFFF0 → next imem_addr=32'h4.
- imem_valid delayed 3 cycles, then exec_done held low for 4 cycles in HOLD → imem_addr stable throughout REQ; instr stable throughout HOLD; no second request issued.
- Reset asserted in REQ, then imem_valid arrives during IDLE → response ignored; fetch restarts at RESET_PC.
- JR to 32'h402:
  - With FETCH_MISALIGN_TRAP_EN → fetch_err=1 the next cycle and imem_req stays 0.
  - Without the macro → next imem_addr=32'h400.
